// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI-Lite responder backed by a bank of software-visible registers.
// Independent write (AW/W/B) and read (AR/R) state machines; every output comes straight from a flop.
module axi_lite_slave_regfile #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 4
) (
    input  logic                          i_aclk,
    input  logic                          i_aresetn,
    input  logic [REG_WIDTH-1:0]          i_awaddr,
    input  logic                          i_awvalid,
    output logic                          o_awready,
    input  logic [REG_WIDTH-1:0]          i_wdata,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    output logic                          o_bvalid,
    input  logic                          i_bready,
    input  logic [REG_WIDTH-1:0]          i_araddr,
    input  logic                          i_arvalid,
    output logic                          o_arready,
    output logic [REG_WIDTH-1:0]          o_rdata,
    output logic                          o_rvalid,
    input  logic                          i_rready,
    output logic [NUM_REGS*REG_WIDTH-1:0] o_regs_out,
    output logic [NUM_REGS-1:0]           o_reg_wr_strobe
);
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_HALF, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t             r_wstate, w_wstate_nx;
    r_state_t             r_rstate, w_rstate_nx;
    logic                 r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic                 w_awready_nx, w_wready_nx, w_bvalid_nx, w_arready_nx, w_rvalid_nx;
    logic [REG_WIDTH-1:0] r_awaddr, r_wdata, r_rdata;
    logic [REG_WIDTH-1:0] w_awaddr_nx, w_wdata_nx, w_rdata_nx;
    logic [REG_WIDTH-1:0] w_cmt_addr, w_cmt_data;
    logic                 w_commit;
    logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  r_strobe;
    logic                 w_aw_hs, w_w_hs, w_ar_hs;
    logic [IW-1:0]        w_wr_idx, w_rd_idx;
    logic                 w_wr_inr, w_rd_inr;
    logic                 w_unused;

    assign w_aw_hs  = i_awvalid && r_awready;
    assign w_w_hs   = i_wvalid && r_wready;
    assign w_ar_hs  = i_arvalid && r_arready;
    // Byte-address bits [1:0] never select anything; the range test just requires the bits above the index to be zero.
    assign w_wr_idx = w_cmt_addr[IW+1:2];
    assign w_wr_inr = (w_cmt_addr[REG_WIDTH-1:IW+2] == '0);
    assign w_rd_idx = i_araddr[IW+1:2];
    assign w_rd_inr = (i_araddr[REG_WIDTH-1:IW+2] == '0);
    assign w_unused = ^{w_cmt_addr[1:0], i_araddr[1:0]};

    // Write FSM next state: collect AW and W in either order, commit once both are known, then wait for B.
    always_comb begin
        w_wstate_nx  = r_wstate;
        w_awready_nx = r_awready;
        w_wready_nx  = r_wready;
        w_bvalid_nx  = r_bvalid;
        w_awaddr_nx  = r_awaddr;
        w_wdata_nx   = r_wdata;
        w_commit     = 1'b0;
        w_cmt_addr   = r_awaddr;
        w_cmt_data   = r_wdata;
        case (r_wstate)
            W_IDLE: begin
                w_awready_nx = 1'b1;
                w_wready_nx  = 1'b1;
                if (w_aw_hs && w_w_hs) begin
                    w_commit   = 1'b1;
                    w_cmt_addr = i_awaddr;
                    w_cmt_data = i_wdata;
                end else if (w_aw_hs) begin
                    w_awaddr_nx  = i_awaddr;
                    w_awready_nx = 1'b0;
                    w_wstate_nx  = W_HALF;
                end else if (w_w_hs) begin
                    w_wdata_nx  = i_wdata;
                    w_wready_nx = 1'b0;
                    w_wstate_nx = W_HALF;
                end
            end
            W_HALF: begin
                if (w_aw_hs) begin
                    w_commit   = 1'b1;
                    w_cmt_addr = i_awaddr;
                end else if (w_w_hs) begin
                    w_commit   = 1'b1;
                    w_cmt_data = i_wdata;
                end
            end
            W_RESP: begin
                if (r_bvalid && i_bready) begin
                    w_bvalid_nx  = 1'b0;
                    w_awready_nx = 1'b1;
                    w_wready_nx  = 1'b1;
                    w_wstate_nx  = W_IDLE;
                end
            end
            default: w_wstate_nx = W_IDLE;
        endcase
        if (w_commit) begin
            w_bvalid_nx  = 1'b1;
            w_awready_nx = 1'b0;
            w_wready_nx  = 1'b0;
            w_wstate_nx  = W_RESP;
        end
    end

    // Write FSM state and channel flops.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
        end else begin
            r_wstate  <= w_wstate_nx;
            r_awready <= w_awready_nx;
            r_wready  <= w_wready_nx;
            r_bvalid  <= w_bvalid_nx;
            r_awaddr  <= w_awaddr_nx;
            r_wdata   <= w_wdata_nx;
        end
    end

    // Register bank: in-range commits update one register and pulse its strobe for exactly one cycle.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_strobe <= '0;
        end else begin
            r_strobe <= '0;
            if (w_commit && w_wr_inr) begin
                r_regs[w_wr_idx]   <= w_cmt_data;
                r_strobe[w_wr_idx] <= 1'b1;
            end
        end
    end

    // Read FSM next state: sample the bank on the AR edge (pre-write value on a collision), hold until R handshake.
    always_comb begin
        w_rstate_nx  = r_rstate;
        w_arready_nx = r_arready;
        w_rvalid_nx  = r_rvalid;
        w_rdata_nx   = r_rdata;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nx = 1'b1;
                if (w_ar_hs) begin
                    w_rdata_nx   = w_rd_inr ? r_regs[w_rd_idx] : '0;
                    w_rvalid_nx  = 1'b1;
                    w_arready_nx = 1'b0;
                    w_rstate_nx  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_rvalid && i_rready) begin
                    w_rvalid_nx  = 1'b0;
                    w_rdata_nx   = '0;
                    w_arready_nx = 1'b1;
                    w_rstate_nx  = R_IDLE;
                end
            end
        endcase
    end

    // Read FSM state and channel flops.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rstate_nx;
            r_arready <= w_arready_nx;
            r_rvalid  <= w_rvalid_nx;
            r_rdata   <= w_rdata_nx;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign o_regs_out[i*REG_WIDTH +: REG_WIDTH] = r_regs[i];
    end

    assign o_awready       = r_awready;
    assign o_wready        = r_wready;
    assign o_bvalid        = r_bvalid;
    assign o_arready       = r_arready;
    assign o_rvalid        = r_rvalid;
    assign o_rdata         = r_rdata;
    assign o_reg_wr_strobe = r_strobe;
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// tb_axi_lite_slave_regfile: vector table plus directed corner sequences; read data checked through a scoreboard queue.
module tb_axi_lite_slave_regfile;
    logic         clk;
    logic         i_aresetn;
    logic [31:0]  i_awaddr, i_wdata, i_araddr;
    logic         i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
    logic         o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [31:0]  o_rdata;
    logic [127:0] o_regs_out;
    logic [3:0]   o_reg_wr_strobe;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_regs [4];
    logic [31:0] rd_q [$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [14];

    axi_lite_slave_regfile #(.REG_WIDTH(32), .NUM_REGS(4)) dut (
        .i_aclk(clk), .i_aresetn(i_aresetn),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_regs_out(o_regs_out), .o_reg_wr_strobe(o_reg_wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_bus();
        return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    // Scoreboard side: every R handshake pops the value queued when its AR was driven.
    always begin
        @(negedge clk);
        #1;
        if (o_rvalid && i_rready) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h expected none", o_rdata);
            end else chk("sb_rdata", o_rdata, rd_q.pop_front());
        end
    end

    task automatic wait_ready(input string name, input bit aw, input bit w, input bit ar);
        int n = 0;
        while (!((!aw || o_awready) && (!w || o_wready) && (!ar || o_arready)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk(name, 0, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        i_awaddr = a; i_wdata = d; i_awvalid = 1'b1; i_wvalid = 1'b1; i_bready = 1'b1;
        wait_ready("wr_ready_timeout", 1, 1, 0);
        @(negedge clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        for (int k = 0; k < 4; k++) if (strb[k]) exp_regs[k] = d;
        chk("wr_bvalid", o_bvalid, 1);
        chk("wr_strobe", o_reg_wr_strobe, strb);
        chk("wr_regs", o_regs_out, model_bus());
        @(negedge clk);
        chk("wr_bvalid_drop", o_bvalid, 0);
        chk("wr_strobe_drop", o_reg_wr_strobe, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] e, input int hold);
        i_araddr = a; i_arvalid = 1'b1; i_rready = (hold == 0);
        rd_q.push_back(e);
        wait_ready("rd_ready_timeout", 0, 0, 1);
        @(negedge clk);
        i_arvalid = 1'b0;
        chk("rd_rvalid", o_rvalid, 1);
        chk("rd_arready_low", o_arready, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("rd_hold_rvalid", o_rvalid, 1);
            chk("rd_hold_rdata", o_rdata, e);
        end
        i_rready = 1'b1;
        @(negedge clk);
        chk("rd_rvalid_drop", o_rvalid, 0);
        chk("rd_rdata_clear", o_rdata, 0);
        chk("rd_arready_back", o_arready, 1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h1};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'h2222_2222, 32'h2};
        vecs[2]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h4};
        vecs[3]  = '{1'b1, 32'h0000_000C, 32'h4444_4444, 32'h8};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 32'h0000_0003, 32'h0,         32'h1111_1111};
        vecs[6]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0};
        vecs[8]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h4444_4444};
        vecs[9]  = '{1'b1, 32'h0000_0007, 32'hCAFE_F00D, 32'h2};
        vecs[10] = '{1'b0, 32'h0000_0004, 32'h0,         32'hCAFE_F00D};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0};
        vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111};
        for (int k = 0; k < 4; k++) exp_regs[k] = '0;

        i_aresetn = 1'b0;
        i_awaddr = '0; i_wdata = '0; i_araddr = '0;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0; i_arvalid = 1'b0; i_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {o_awready, o_wready, o_arready}, 3'b000);
        chk("rst_valid", {o_bvalid, o_rvalid}, 2'b00);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_strobe", o_reg_wr_strobe, 0);
        chk("rst_regs", o_regs_out, 0);
        i_aresetn = 1'b1;
        #1 chk("release_ready_still_low", o_awready, 0);
        @(negedge clk);
        chk("release_ready", {o_awready, o_wready, o_arready}, 3'b111);

        // Split write: AW first, W three cycles later, B accepted late.
        i_awaddr = 32'h4; i_awvalid = 1'b1; i_bready = 1'b0;
        @(negedge clk);
        i_awvalid = 1'b0;
        chk("split_awready_low", {o_awready, o_wready}, 2'b01);
        chk("split_no_b", o_bvalid, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("split_wait_awready", o_awready, 0);
            chk("split_wait_regs", o_regs_out, 0);
        end
        i_wdata = 32'h1234_5678; i_wvalid = 1'b1;
        @(negedge clk);
        i_wvalid = 1'b0;
        exp_regs[1] = 32'h1234_5678;
        chk("split_bvalid", o_bvalid, 1);
        chk("split_strobe", o_reg_wr_strobe, 4'b0010);
        chk("split_regs", o_regs_out, model_bus());
        chk("split_ready_low", {o_awready, o_wready}, 2'b00);
        @(negedge clk);
        chk("split_bvalid_held", o_bvalid, 1);
        chk("split_strobe_once", o_reg_wr_strobe, 0);
        i_bready = 1'b1;
        @(negedge clk);
        chk("split_b_done", o_bvalid, 0);
        chk("split_ready_back", {o_awready, o_wready}, 2'b11);

        do_read(32'h4, 32'h1234_5678, 3);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].exp[3:0]);
            else do_read(vecs[v].addr, vecs[v].exp, v % 2);
        end

        // Collision: read and write reg0 on one edge, then reset while B is pending.
        do_write(32'h0, 32'h0000_00A5, 4'b0001);
        i_bready = 1'b0; i_rready = 1'b1;
        i_awaddr = 32'h0; i_wdata = 32'h0000_005A; i_araddr = 32'h0;
        i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
        rd_q.push_back(32'h0000_00A5);
        @(negedge clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        exp_regs[0] = 32'h0000_005A;
        chk("coll_rdata_old", o_rdata, 32'h0000_00A5);
        chk("coll_regs_new", o_regs_out, model_bus());
        chk("coll_bvalid", o_bvalid, 1);
        @(negedge clk);
        chk("coll_bvalid_held", o_bvalid, 1);
        i_aresetn = 1'b0;
        #1;
        chk("midrst_bvalid", o_bvalid, 0);
        chk("midrst_regs", o_regs_out, 0);
        chk("midrst_ready", {o_awready, o_wready, o_arready}, 3'b000);
        @(negedge clk);
        i_aresetn = 1'b1;
        @(negedge clk);
        chk("rerelease_ready", {o_awready, o_wready, o_arready}, 3'b111);
        chk("sb_empty", rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
